dc_ram_req_ctrl: RTL
====================

// Module: dc_ram_req_ctrl
// PURPOSE
//  Initiator side of the dcache data-RAM port: accepts byte-masked read/write requests over a
//  valid/ready handshake and drives the RAM's en/rw/bit_mask/addr/din pins. Captures the
//  registered 1-cycle-latency qout and returns it over a valid/ready response channel.
//  Sits between the dcache pipeline/refill logic and the data-array RAM instance.
// PARAMETERS
//  DEPTH       2               RAM entries (index count)
//  WIDTH       256             RAM word width in bits
//  WIDTH_BYTE  WIDTH/8         byte lanes per word
//  ADDR_WIDTH  $clog2(DEPTH)   index width
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous reset, active-high
//  req_valid      in   1           request valid
//  req_ready      out  1           request accepted when valid&ready
//  req_rw         in   1           0=read, 1=write
//  req_addr       in   ADDR_WIDTH  RAM index
//  req_wdata      in   WIDTH       write data
//  req_byte_mask  in   WIDTH_BYTE  write byte enables (ignored for reads)
//  resp_valid     out  1           read data valid
//  resp_ready     in   1           consumer accepts read data
//  resp_rdata     out  WIDTH       read data
//  ram_en         out  1           to RAM en
//  ram_rw         out  1           to RAM rw
//  ram_bit_mask   out  WIDTH       to RAM bit_mask; bit i = req_byte_mask[i/8]
//  ram_addr       out  ADDR_WIDTH  to RAM addr
//  ram_din        out  WIDTH       to RAM din
//  ram_qout       in   WIDTH       from RAM qout (registered, valid the cycle after a read)
// BEHAVIOUR
//  - Reset: state=IDLE (INIT with macro); req_ready=0, resp_valid=0, ram_en=0 while rst high.
//  - States: IDLE (ready=1), RD_RESP (resp_valid=1), INIT (macro only, ready=0).
//  - ram_* are combinational from the accepted request; ram_en = req_valid & req_ready & (rd | |mask).
//  - Write: single cycle; RAM written at the accept edge; no response; stays in IDLE.
//  - Write with byte_mask==0: accepted, ram_en=0 (no-op).
//  - Read accepted in cycle T: RAM en&~rw in T; IDLE->RD_RESP; resp_valid=1 from T+1,
//    resp_rdata = ram_qout (RAM holds qout while no further read is issued).
//  - RD_RESP & resp_ready=0: hold; req_ready=0; ram_en=0 (qout stable).
//  - RD_RESP & resp_ready=1: req_ready=1 the same cycle (back-to-back); new read -> stay
//    RD_RESP; write or no request -> IDLE. Sustained reads give 1 response per cycle.
//  - Read after write to same index in next cycle returns the new data (RAM write precedes read).
//  - Reset mid-operation: pending response dropped; resp_valid=0 the cycle after rst.
// CONFIGURATION
//  DC_RAM_REQ_CTRL_ZEROIZE_EN defined: after reset, INIT walks index 0..DEPTH-1 writing 0
//    with all-ones bit_mask, one index per cycle (DEPTH cycles), req_ready=0 throughout,
//    then IDLE. Reset during INIT restarts from index 0.
//  Not defined: no INIT state; req_ready=1 in the first cycle after rst deasserts.
// STRUCTURE
//  - Package dc_ram_req_ctrl_pkg: state enum (IDLE, RD_RESP, INIT), function
//    byte_to_bit_mask(WIDTH_BYTE -> WIDTH), RW_READ/RW_WRITE constants.
//  - No sub-module; the parent instantiates the RAM and wires ram_* pins to it.
// TESTING
//  1 Reset then idle: rst 3 cycles -> req_ready=0, resp_valid=0, ram_en=0; ready=1 after
//    (DEPTH cycles later with ZEROIZE_EN).
//  2 Write addr 1, data 0xA5.., byte_mask 0x0000_000F; read addr 1 -> resp_rdata low 32b =
//    write data, other bits unchanged; resp_valid exactly 1 cycle after read accept.
//  3 Reads addr 0,1,0 back-to-back, resp_ready=1 -> 3 responses on 3 consecutive cycles, in order.
//  4 Read with resp_ready=0 for 5 cycles, req_valid held -> resp_valid/rdata stable,
//    req_ready=0, ram_en=0; release -> response consumed, next request accepted same cycle.
//  5 Write byte_mask=0 -> accepted, ram_en=0, later read shows unchanged data.
//  6 rst asserted in RD_RESP -> resp_valid=0 next cycle; no stale response after reset;
//    with ZEROIZE_EN all indices read back 0.

Source files
------------

// File: rtl/dc_ram_req_ctrl_pkg.sv
// Shared types and helpers for the dcache data-RAM request controller:
// controller state encoding, RAM read/write strobe values and the
// byte-enable to bit-enable expansion used on the RAM bit_mask pins.
package dc_ram_req_ctrl_pkg;

    localparam int DC_DEPTH      = 2;
    localparam int DC_WIDTH      = 256;
    localparam int DC_WIDTH_BYTE = DC_WIDTH / 8;

    // Encoding of the RAM rw pin and of req_rw.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_RESP = 2'd1,
        INIT    = 2'd2
    } state_e;

    // Every byte enable covers the eight bits of its lane.
    function automatic logic [DC_WIDTH-1:0] byte_to_bit_mask(
        input logic [DC_WIDTH_BYTE-1:0] byte_mask
    );
        logic [DC_WIDTH-1:0] bit_mask;
        bit_mask = '0;
        for (int i = 0; i < DC_WIDTH; i++) begin
            bit_mask[i] = byte_mask[i / 8];
        end
        return bit_mask;
    endfunction

endpackage

// File: rtl/dc_ram_req_ctrl.sv
// Initiator side of the dcache data-RAM port.
// Accepts byte-masked read/write requests on a valid/ready channel and drives
// the RAM pins combinationally from the accepted request. Read data comes back
// from the RAM one cycle later on qout and is presented on a valid/ready
// response channel; the RAM holds qout while no new read is issued, so a
// stalled response needs no local data register.
// Optional build macro DC_RAM_REQ_CTRL_ZEROIZE_EN: after reset, walk every
// index writing zero (one index per cycle) before accepting requests.
module dc_ram_req_ctrl
    import dc_ram_req_ctrl_pkg::*;
#(
    parameter int DEPTH      = DC_DEPTH,
    parameter int WIDTH      = DC_WIDTH,
    parameter int WIDTH_BYTE = WIDTH / 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    input  logic [WIDTH_BYTE-1:0] req_byte_mask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  ram_en,
    output logic                  ram_rw,
    output logic [WIDTH-1:0]      ram_bit_mask,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_din,
    input  logic [WIDTH-1:0]      ram_qout
);

`ifdef DC_RAM_REQ_CTRL_ZEROIZE_EN
    localparam state_e RESET_STATE = INIT;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
`else
    localparam state_e RESET_STATE = IDLE;
`endif

    state_e                  state_q;
    state_e                  state_d;
`ifdef DC_RAM_REQ_CTRL_ZEROIZE_EN
    logic [ADDR_WIDTH-1:0]   init_idx_q;
    logic [ADDR_WIDTH-1:0]   init_idx_d;
`endif

    logic                    ready_raw_s;
    logic                    req_ready_s;
    logic                    resp_valid_s;
    logic                    accept_s;
    logic                    is_rd_s;
    logic                    ram_en_s;
    logic                    ram_rw_s;
    logic [WIDTH-1:0]        ram_bit_mask_s;
    logic [ADDR_WIDTH-1:0]   ram_addr_s;
    logic [WIDTH-1:0]        ram_din_s;

    // Handshake qualifiers, RAM pin drive and next-state selection.
    always_comb begin
        state_d        = state_q;
`ifdef DC_RAM_REQ_CTRL_ZEROIZE_EN
        init_idx_d     = init_idx_q;
`endif
        ready_raw_s    = 1'b0;
        resp_valid_s   = 1'b0;
        ram_rw_s       = req_rw;
        ram_addr_s     = req_addr;
        ram_din_s      = req_wdata;
        ram_bit_mask_s = byte_to_bit_mask(req_byte_mask);

        case (state_q)
            IDLE: begin
                ready_raw_s = 1'b1;
            end
            RD_RESP: begin
                // Consuming the response frees the port in the same cycle.
                ready_raw_s  = resp_ready;
                resp_valid_s = 1'b1;
            end
            INIT: begin
                ready_raw_s = 1'b0;
            end
            default: begin
                ready_raw_s = 1'b0;
            end
        endcase

        // Nothing is offered or issued while reset is held.
        req_ready_s = ready_raw_s & ~rst;
        resp_valid_s = resp_valid_s & ~rst;
        accept_s    = req_valid & req_ready_s;
        is_rd_s     = (req_rw == RW_READ);
        // A write with no enabled bytes is accepted but never reaches the RAM.
        ram_en_s    = accept_s & (is_rd_s | (|req_byte_mask));

        case (state_q)
            IDLE: begin
                if (accept_s && is_rd_s) begin
                    state_d = RD_RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_RESP: begin
                if (resp_ready) begin
                    if (accept_s && is_rd_s) begin
                        state_d = RD_RESP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RD_RESP;
                end
            end
            INIT: begin
`ifdef DC_RAM_REQ_CTRL_ZEROIZE_EN
                ram_en_s       = ~rst;
                ram_rw_s       = RW_WRITE;
                ram_addr_s     = init_idx_q;
                ram_din_s      = '0;
                ram_bit_mask_s = '1;
                if (init_idx_q == LAST_IDX) begin
                    state_d    = IDLE;
                    init_idx_d = '0;
                end else begin
                    state_d    = INIT;
                    init_idx_d = init_idx_q + ADDR_WIDTH'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DC_RAM_REQ_CTRL_ZEROIZE_EN
    // Zeroize walk index; restarts from index 0 on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx_q <= '0;
        end else begin
            init_idx_q <= init_idx_d;
        end
    end
`endif

    assign req_ready    = req_ready_s;
    assign resp_valid   = resp_valid_s;
    assign resp_rdata   = ram_qout;
    assign ram_en       = ram_en_s;
    assign ram_rw       = ram_rw_s;
    assign ram_bit_mask = ram_bit_mask_s;
    assign ram_addr     = ram_addr_s;
    assign ram_din      = ram_din_s;

endmodule
